// File: rtl/neurram_nmlo_readout.sv
// -----------------------------------------------------------------------------
// neurram_nmlo_readout
//
// Captures the NMLO neuron-output vector recorded by the SPI controller and
// streams it to a host pipe-out FIFO as 32-bit words. Each frame is NWORDS data
// words followed by one trailer word {acc2, acc1, acc0, frame_seq}, where accN
// is the popcount of core N's bits. Runs in the SPI controller's clock domain.
//
// Ports:
//   clk               system clock (same as the SPI controller)
//   rst               asynchronous active-low reset
//   capture_req       one-cycle request to capture and stream one frame
//   spi_idle          SPI controller idle flag; capture waits for it
//   spi_from_neurram  recorded NMLO vector, nmlo_length bits per core
//   out_fifo_full     downstream FIFO full; stalls streaming
//   out_fifo_wr_en    write strobe, one word per asserted cycle
//   out_fifo_din      word written (0 whenever out_fifo_wr_en is low)
//   busy              high whenever a frame is pending or in progress
//   frame_seq         completed frame count, wraps 255 -> 0
//   drop_count        requests ignored while busy, saturates at 255
// -----------------------------------------------------------------------------
module neurram_nmlo_readout #(
    parameter int unsigned nmlo_length = 128,  // multiple of 32, at most 224
    parameter int unsigned nmlo_core   = 3     // 1..3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               capture_req,
    input  logic                               spi_idle,
    input  logic [nmlo_length*nmlo_core-1:0]   spi_from_neurram,
    input  logic                               out_fifo_full,
    output logic                               out_fifo_wr_en,
    output logic [31:0]                        out_fifo_din,
    output logic                               busy,
    output logic [7:0]                         frame_seq,
    output logic [7:0]                         drop_count
);

    localparam int unsigned WPC    = nmlo_length / 32;
    localparam int unsigned NWORDS = WPC * nmlo_core;
    localparam int unsigned VW     = nmlo_length * nmlo_core;
    localparam int unsigned IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitIdle,
        StLoad,
        StStream,
        StTrailer
    } state_e;

    state_e            r_state;
    logic [VW-1:0]     r_snap;
    logic [IDXW-1:0]   r_idx;
    // Always three accumulators so the trailer layout is fixed; fields for
    // cores beyond nmlo_core are never written and stay 0.
    logic [7:0]        r_acc [3];
    logic              r_busy;
    logic [7:0]        r_seq;
    logic [7:0]        r_drop;

    logic [31:0]       w_words [NWORDS];
    logic [31:0]       w_cur_word;
    logic [7:0]        w_pop;
    logic              w_last;
    logic [31:0]       w_trailer;

    // Number of set bits in one 32-bit word (fits in 6 bits, kept at 8).
    function automatic logic [7:0] popcount32(input logic [31:0] w);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {7'd0, w[i]};
        end
        return n;
    endfunction

    // Split the snapshot into words; word k is snapshot[32k+31:32k].
    for (genvar gk = 0; gk < NWORDS; gk++) begin : g_words
        assign w_words[gk] = r_snap[32*gk +: 32];
    end

    assign w_cur_word = w_words[r_idx];
    assign w_pop      = popcount32(w_cur_word);
    assign w_last     = (r_idx == IDXW'(NWORDS - 1));
    assign w_trailer  = {r_acc[2], r_acc[1], r_acc[0], r_seq};

    // Write strobe and data are combinational so a full FIFO blocks the write
    // in the same cycle; the word is simply re-presented next cycle.
    always_comb begin
        out_fifo_wr_en = 1'b0;
        out_fifo_din   = '0;
        if (!out_fifo_full) begin
            if (r_state == StStream) begin
                out_fifo_wr_en = 1'b1;
                out_fifo_din   = w_cur_word;
            end else if (r_state == StTrailer) begin
                out_fifo_wr_en = 1'b1;
                out_fifo_din   = w_trailer;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_snap  <= '0;
            r_idx   <= '0;
            for (int c = 0; c < 3; c++) begin
                r_acc[c] <= '0;
            end
            r_busy  <= 1'b0;
            r_seq   <= '0;
            r_drop  <= '0;
        end else begin
            // Requests are never queued: any request outside IDLE is counted
            // and dropped, including one coinciding with TRAILER -> IDLE.
            if (capture_req && (r_state != StIdle) && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end

            case (r_state)
                StIdle: begin
                    if (capture_req) begin
                        r_state <= StWaitIdle;
                        r_busy  <= 1'b1;
                    end
                end

                StWaitIdle: begin
                    if (spi_idle) begin
                        r_state <= StLoad;
                    end
                end

                StLoad: begin
                    r_snap <= spi_from_neurram;
                    r_idx  <= '0;
                    for (int c = 0; c < 3; c++) begin
                        r_acc[c] <= '0;
                    end
                    r_state <= StStream;
                end

                StStream: begin
                    if (!out_fifo_full) begin
                        // Word k belongs to core k / WPC.
                        for (int c = 0; c < int'(nmlo_core); c++) begin
                            if ((int'(r_idx) / int'(WPC)) == c) begin
                                r_acc[c] <= r_acc[c] + w_pop;
                            end
                        end
                        if (w_last) begin
                            r_state <= StTrailer;
                        end else begin
                            r_idx <= r_idx + IDXW'(1);
                        end
                    end
                end

                StTrailer: begin
                    if (!out_fifo_full) begin
                        r_seq   <= r_seq + 8'd1;
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign frame_seq  = r_seq;
    assign drop_count = r_drop;

endmodule
